// File: rtl/idex_alu_decode.sv
// idex_alu_decode: RV32I ALU-op decode registered into the ID/EX boundary; IDEX_DEC_AUIPC_EN adds AUIPC
module idex_alu_decode #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [31:0]     id_instr,
  input  logic            stall,
  input  logic            flush,
  output logic            ex_valid,
  output logic [3:0]      ex_alu_op,
  output logic            ex_alu_src_imm,
  output logic            ex_alu_src_pc,
  output logic [XLEN-1:0] ex_imm,
  output logic            ex_illegal
);
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_LUI  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_SLT  = 4'd9;
  localparam logic [3:0] OP_SLTU = 4'd10;

  logic [6:0]      opc, f7;
  logic [2:0]      f3;
  logic            f7_zero, f7_alt, is_shift;
  logic [3:0]      base_op;
  logic [3:0]      dec_op;
  logic            dec_src_imm, dec_src_pc, dec_ill;
  logic [XLEN-1:0] dec_imm;
  logic            valid_d, valid_q, src_imm_d, src_imm_q, src_pc_d, src_pc_q, ill_d, ill_q;
  logic [3:0]      op_d, op_q;
  logic [XLEN-1:0] imm_d, imm_q;

  assign opc      = id_instr[6:0];
  assign f3       = id_instr[14:12];
  assign f7       = id_instr[31:25];
  assign f7_zero  = f7 == 7'h00;
  assign f7_alt   = f7 == 7'h20;
  assign is_shift = f3 == 3'b001 || f3 == 3'b101;

  // funct3 -> ALU op for the non-alternate (funct7 = 0) encodings shared by R- and I-type
  always_comb begin
    base_op = OP_ADD;
    case (f3)
      3'b001:  base_op = OP_SLL;
      3'b010:  base_op = OP_SLT;
      3'b011:  base_op = OP_SLTU;
      3'b100:  base_op = OP_XOR;
      3'b101:  base_op = OP_SRL;
      3'b110:  base_op = OP_OR;
      3'b111:  base_op = OP_AND;
      default: base_op = OP_ADD;
    endcase
  end

  // instruction decode; an illegal word collapses to add/rs2/imm 0 with only the flag set
  always_comb begin
    dec_op      = OP_ADD;
    dec_src_imm = 1'b0;
    dec_src_pc  = 1'b0;
    dec_imm     = '0;
    dec_ill     = 1'b0;
    case (opc)
      7'b0110011: begin
        dec_ill = !(f7_zero || (f7_alt && (f3 == 3'b000 || f3 == 3'b101)));
        dec_op  = f7_alt ? (f3 == 3'b000 ? OP_SUB : OP_SRA) : base_op;
      end
      7'b0010011: begin
        dec_src_imm = 1'b1;
        dec_ill     = is_shift && !(f7_zero || (f7_alt && f3 == 3'b101));
        dec_op      = is_shift && f7_alt ? OP_SRA : base_op;
        dec_imm     = is_shift ? {27'b0, id_instr[24:20]} : {{20{id_instr[31]}}, id_instr[31:20]};
      end
      7'b0110111: begin
        dec_op      = OP_LUI;
        dec_src_imm = 1'b1;
        dec_imm     = {id_instr[31:12], 12'b0};
      end
      7'b0000011: begin
        dec_src_imm = 1'b1;
        dec_imm     = {{20{id_instr[31]}}, id_instr[31:20]};
      end
      7'b0100011: begin
        dec_src_imm = 1'b1;
        dec_imm     = {{20{id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
      end
      7'b1100011: dec_op = OP_SUB;
`ifdef IDEX_DEC_AUIPC_EN
      7'b0010111: begin
        dec_src_imm = 1'b1;
        dec_src_pc  = 1'b1;
        dec_imm     = {id_instr[31:12], 12'b0};
      end
`endif
      default: dec_ill = 1'b1;
    endcase
    if (dec_ill) begin
      dec_op      = OP_ADD;
      dec_src_imm = 1'b0;
      dec_src_pc  = 1'b0;
      dec_imm     = '0;
    end
  end

  // flush beats stall; stall holds; an empty ID slot becomes a bubble
  always_comb begin
    valid_d   = flush ? 1'b0 : stall ? valid_q   : id_valid;
    op_d      = flush ? '0   : stall ? op_q      : id_valid ? dec_op      : '0;
    src_imm_d = flush ? 1'b0 : stall ? src_imm_q : id_valid && dec_src_imm;
    src_pc_d  = flush ? 1'b0 : stall ? src_pc_q  : id_valid && dec_src_pc;
    imm_d     = flush ? '0   : stall ? imm_q     : id_valid ? dec_imm     : '0;
    ill_d     = flush ? 1'b0 : stall ? ill_q     : id_valid && dec_ill;
  end

  // ID/EX pipeline register, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      op_q      <= '0;
      src_imm_q <= 1'b0;
      src_pc_q  <= 1'b0;
      imm_q     <= '0;
      ill_q     <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      op_q      <= op_d;
      src_imm_q <= src_imm_d;
      src_pc_q  <= src_pc_d;
      imm_q     <= imm_d;
      ill_q     <= ill_d;
    end
  end

  assign ex_valid       = valid_q;
  assign ex_alu_op      = op_q;
  assign ex_alu_src_imm = src_imm_q;
  assign ex_alu_src_pc  = src_pc_q;
  assign ex_imm         = imm_q;
  assign ex_illegal     = ill_q;
endmodule

// File: doc/idex_alu_decode.md
Name: idex_alu_decode

Overview:
- ID-side producer of the 4-bit ALU operation code consumed by the EX-stage ALU result select.
- Decodes RV32I opcode/funct3/funct7 into an ALU op, operand-B source select and immediate.
- Registers all results into the ID/EX pipeline boundary.
- Supports stall (hold) and flush (bubble) from the hazard unit.

Parameters:
- XLEN, 32, datapath/immediate width; only 32 is supported.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- id_valid  input  1  ID stage holds a real instruction
- id_instr  input  32  instruction word in ID
- stall  input  1  hold ID/EX register contents
- flush  input  1  replace ID/EX contents with a bubble
- ex_valid  output  1  registered valid
- ex_alu_op  output  4  registered ALU op code
- ex_alu_src_imm  output  1  1 = operand B is ex_imm, 0 = rs2
- ex_alu_src_pc  output  1  1 = operand A is PC (AUIPC only; see Optional Feature)
- ex_imm  output  32  registered immediate
- ex_illegal  output  1  registered illegal-instruction flag

Behaviour:
- Op encoding (fixed):
  - add=0, sub=1, lui=2, and=3, xor=4, or=5, sll=6, srl=7, sra=8, slt=9, sltu=10.
  - Codes 11-15 are never produced.
- Decode is combinational from id_instr; every output is registered (1-cycle latency ID->EX).
- R-type, opcode 0110011, src_imm=0:
  - f3 000: funct7 0x00 -> add, 0x20 -> sub.
  - f3 001 sll, 010 slt, 011 sltu, 100 xor, 110 or, 111 and: require funct7 0x00.
  - f3 101: funct7 0x00 -> srl, 0x20 -> sra.
  - Any other funct7 -> illegal.
- I-type ALU, opcode 0010011, src_imm=1:
  - f3 000 add, 010 slt, 011 sltu, 100 xor, 110 or, 111 and; imm = sign-extended instr[31:20].
  - f3 001 sll: funct7 must be 0x00.
  - f3 101: funct7 0x00 -> srl, 0x20 -> sra.
  - Shift imm = zero-extended instr[24:20].
  - Bad funct7 on a shift -> illegal.
- LUI, opcode 0110111: op lui, src_imm=1, imm = {instr[31:12], 12'b0}.
- Load, opcode 0000011: op add, src_imm=1, I-immediate.
- Store, opcode 0100011: op add, src_imm=1, S-immediate {sext instr[31:25], instr[11:7]}.
- Branch, opcode 1100011: op sub, src_imm=0, imm = 0.
- Any other opcode -> illegal.
- Illegal registers as: ex_illegal=1, op add, src_imm=0, imm=0, ex_valid=id_valid.
- Register update priority, evaluated every clock:
  - flush=1: bubble; overrides stall.
  - else stall=1: hold all outputs.
  - else id_valid=0: bubble.
  - else: load decoded values, ex_valid=1.
- Bubble = ex_valid 0, op 0, src_imm 0, src_pc 0, imm 0, illegal 0.
- Reset: all outputs 0, asynchronously on rst_n low.
  - First load occurs at the first rising edge after rst_n deasserts.
  - A reset mid-stream discards any held instruction.
- ex_illegal is meaningful only when ex_valid=1; it is never asserted with ex_valid=0.

Optional Feature:
- Macro: IDEX_DEC_AUIPC_EN.
- Defined: opcode 0010111 decodes to op add, src_imm=1, src_pc=1, imm = {instr[31:12], 12'b0}.
- Undefined:
  - 0010111 is illegal.
  - ex_alu_src_pc port still exists and is constant 0.

Test Plan:
- Reset, then id_valid=1 with 0x002081B3 (add x3,x1,x2) -> next edge: valid 1, op 0, src_imm 0, imm 0, illegal 0. Then 0x402081B3 -> op 1.
- 0x40435293 (srai x5,x6,4) -> op 8, src_imm 1, imm 0x00000004. Then 0xFFF00093 (addi x1,x0,-1) -> op 0, imm 0xFFFFFFFF. Then 0x123450B7 (lui) -> op 2, imm 0x12345000.
- Load 0xFFF00093, then stall=1 for 3 cycles while id_instr=0x002081B3 -> outputs hold imm 0xFFFFFFFF. Stall=1 with flush=1 on the same edge -> bubble, all zero.
- 0xFFFFFFFF with id_valid=1 -> valid 1, illegal 1, op 0. 0x802081B3 (bad funct7) -> illegal 1. Same word with id_valid=0 -> valid 0, illegal 0.
- 0x00000097 (auipc x1,0): with IDEX_DEC_AUIPC_EN -> op 0, src_pc 1, src_imm 1, illegal 0. Without the macro -> illegal 1, src_pc 0.
- Stream of 4 valid instructions, rst_n pulsed low mid-cycle -> outputs zero immediately, before any clock edge. After release, the next instruction loads normally.
